// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator (integrators at input rate, decimate by R, combs at output rate)
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   i_data  in   WIN-bit signed sample, taken when val_in=1
//   val_in  in   input strobe
//   o_data  out  WOUT-bit signed output, top bits of the last comb, held between strobes
//   val_out out  one-cycle strobe marking a new o_data
module cic_decimator #(
  parameter int WIN  = 16,
  parameter int N    = 3,
  parameter int R    = 8,
  parameter int WG   = 9,
  parameter int WOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIN-1:0]  i_data,
  input  logic            val_in,
  output logic [WOUT-1:0] o_data,
  output logic            val_out
);
  localparam int W  = WIN + WG;
  localparam int CW = $clog2(R);
  logic [W-1:0]  integ_q [N];
  logic [W-1:0]  integ_d [N];
  logic [W-1:0]  comb_q  [N];
  logic [W-1:0]  comb_d  [N];
  logic [W-1:0]  dly_q   [N];
  logic [W-1:0]  dly_d   [N];
  logic [W-1:0]  x       [N];
  logic [N-1:0]  xv;
  logic [N-1:0]  vld_q, vld_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dec_v_q, dec_v_d;
  always_comb begin
    integ_d = integ_q;
    if (val_in) begin
      integ_d[0] = integ_q[0] + {{WG{i_data[WIN-1]}}, i_data};
      for (int k = 1; k < N; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
    end
    // R is a power of two, so the counter wraps from R-1 to 0 on its own
    cnt_d   = val_in ? cnt_q + CW'(1) : cnt_q;
    dec_v_d = val_in && (cnt_q == CW'(R - 1));
    x[0]  = integ_q[N-1];
    xv[0] = dec_v_q;
    for (int k = 1; k < N; k++) begin
      x[k]  = comb_q[k-1];
      xv[k] = vld_q[k-1];
    end
    for (int k = 0; k < N; k++) begin
      comb_d[k] = xv[k] ? x[k] - dly_q[k] : comb_q[k];
      dly_d[k]  = xv[k] ? x[k] : dly_q[k];
    end
    vld_d = xv;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      integ_q <= '{default: '0};
      comb_q  <= '{default: '0};
      dly_q   <= '{default: '0};
      vld_q   <= '0;
      cnt_q   <= '0;
      dec_v_q <= 1'b0;
    end else begin
      integ_q <= integ_d;
      comb_q  <= comb_d;
      dly_q   <= dly_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      dec_v_q <= dec_v_d;
    end
  end
  assign o_data  = comb_q[N-1][W-1 -: WOUT];
  assign val_out = vld_q[N-1];
endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: directed self-checking bench for cic_decimator (N=3, R=8)
module tb_cic_decimator;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [15:0]        i_data = '0;
  logic               val_in = 1'b0;
  logic signed [15:0] o_data;
  logic               val_out;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int outs[$];
  int stamps[$];
  cic_decimator dut (
    .clk(clk), .rst(rst), .i_data(i_data), .val_in(val_in),
    .o_data(o_data), .val_out(val_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input logic v, input int d);
    i_data = 16'(d);
    val_in = v;
    @(posedge clk);
    #1;
    cyc++;
    if (val_out) begin
      outs.push_back(int'(o_data));
      stamps.push_back(cyc);
    end
  endtask
  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    outs.delete();
    stamps.delete();
  endtask
  initial begin
    int c0, c8, bad, sum;
    for (int i = 0; i < 6; i++) begin
      tick(i[0], 1234);
      chk("rst_hold_vout", int'(val_out), 0);
      chk("rst_hold_data", int'(o_data), 0);
    end
    #3 rst = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b1, 512);
    tick(1'b0, 0);
    chk("lat_e1", int'(val_out), 0);
    tick(1'b0, 0);
    chk("lat_e2", int'(val_out), 0);
    tick(1'b0, 0);
    chk("lat_e3", int'(val_out), 1);
    chk("lat_first_val", int'(o_data), 56);
    tick(1'b0, 0);
    chk("lat_e4", int'(val_out), 0);
    chk("hold_data", int'(o_data), 56);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_data", int'(o_data), 0);
    chk("async_rst_vout", int'(val_out), 0);
    #1 rst = 1'b1;
    outs.delete();
    stamps.delete();
    c0 = cyc;
    for (int i = 0; i < 70; i++) tick(1'b1, 1000);
    chk("dc_cont_count", outs.size(), 8);
    if (outs.size() == 8) begin
      chk("dc_cont_first_t", stamps[0] - c0, 11);
      chk("dc_cont_spacing", stamps[5] - stamps[4], 8);
      chk("dc_cont_o1", outs[0], 109);
      chk("dc_cont_o2", outs[1], 765);
      for (int i = 2; i < 8; i++) chk("dc_cont_ss", outs[i], 1000);
    end
    pulse_reset();
    c0 = cyc;
    for (int i = 0; i < 150; i++) tick(i % 3 == 0, -2500);
    chk("dc_sparse_count", outs.size(), 6);
    if (outs.size() == 6) begin
      chk("dc_sparse_first_t", stamps[0] - c0, 25);
      chk("dc_sparse_spacing", stamps[3] - stamps[2], 24);
      chk("dc_sparse_o1", outs[0], -274);
      chk("dc_sparse_o2", outs[1], -1915);
      for (int i = 2; i < 6; i++) chk("dc_sparse_ss", outs[i], -2500);
    end
    pulse_reset();
    tick(1'b1, 512);
    for (int i = 1; i < 51; i++) tick(1'b1, 0);
    chk("imp_count", outs.size(), 6);
    if (outs.size() == 6) begin
      chk("imp_o1", outs[0], 21);
      chk("imp_o2", outs[1], 42);
      chk("imp_o3", outs[2], 1);
      chk("imp_o4", outs[3], 0);
      chk("imp_o6", outs[5], 0);
      sum = 0;
      foreach (outs[i]) sum += outs[i];
      chk("imp_sum", sum, 64);
    end
    pulse_reset();
    for (int i = 0; i < 512; i++) tick(1'b1, 32767);
    for (int i = 0; i < 512; i++) tick(1'b1, -32768);
    for (int i = 0; i < 4; i++) tick(1'b0, 0);
    chk("wrap_count", outs.size(), 128);
    if (outs.size() == 128) begin
      bad = 0;
      for (int i = 3; i < 64; i++) if (outs[i] != 32767) bad++;
      chk("wrap_hi_bad", bad, 0);
      chk("wrap_hi_last", outs[63], 32767);
      bad = 0;
      for (int i = 67; i < 128; i++) if (outs[i] != -32768) bad++;
      chk("wrap_lo_bad", bad, 0);
      chk("wrap_lo_last", outs[127], -32768);
    end
    pulse_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, 512);
    rst = 1'b0;
    tick(1'b0, 512);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 512);
    for (int i = 0; i < 4; i++) tick(1'b0, 0);
    chk("midrst_no_out", outs.size(), 0);
    for (int i = 0; i < 5; i++) tick(1'b1, 512);
    c8 = cyc;
    for (int i = 0; i < 5; i++) tick(1'b0, 0);
    chk("midrst_count", outs.size(), 1);
    if (outs.size() == 1) begin
      chk("midrst_lat", stamps[0] - c8, 3);
      chk("midrst_val", outs[0], 56);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
